// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch prefetch stage.
// Owns the sequential fetch address, issues one word read at a time to
// instruction memory over req/ack, and buffers returned words with their
// addresses in a small FIFO that decode drains over valid/ready.
// A redirect flushes the FIFO and restarts fetch at a word-aligned address.
// If a request is still outstanding when the redirect arrives, its
// response is discarded.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no request outstanding (FIFO full, or just out of reset)
//   S_WAIT  | request at fetch_pc outstanding, response will be buffered
//   S_DRAIN | stale request outstanding after redirect, response dropped
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    output logic [31:0] o_fetch_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [PW-1:0] PTR_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_addr;
    logic          r_req;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic          r_inst_valid;
    logic [31:0]   r_inst;
    logic [31:0]   r_inst_pc;

    logic          w_ack;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_kept;
    logic [CW-1:0] w_count_nxt;
    logic          w_space;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_wptr_nxt;
    logic          w_head_valid_nxt;
    logic [31:0]   w_head_inst_nxt;
    logic [31:0]   w_head_pc_nxt;

    // Handshake qualification, FIFO occupancy and fetch address update.
    always_comb begin
        w_ack          = i_imem_ack & (r_state != S_IDLE);
        w_pop          = r_inst_valid & i_inst_ready & ~i_redirect;
        w_push         = w_ack & (r_state == S_WAIT) & ~i_redirect;
        w_redirect_pc  = i_redirect_pc & 32'hFFFF_FFFC;
        w_count_kept   = r_count - CW'(w_pop);
        w_count_nxt    = CNT_ZERO;
        w_fetch_pc_nxt = r_fetch_pc;
        w_rptr_nxt     = PTR_ZERO;
        w_wptr_nxt     = PTR_ZERO;
        if (!i_redirect) begin
            w_count_nxt = w_count_kept + CW'(w_push);
            w_rptr_nxt  = r_rptr + PW'(w_pop);
            w_wptr_nxt  = r_wptr + PW'(w_push);
        end
        if (i_redirect) begin
            w_fetch_pc_nxt = w_redirect_pc;
        end else if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
        // The space check sees the entry being pushed this cycle.
        w_space = (w_count_nxt < DEPTH_C);
    end

    // Next head of the FIFO, so the decode-side outputs can be registered.
    always_comb begin
        w_head_valid_nxt = 1'b0;
        w_head_inst_nxt  = 32'h0;
        w_head_pc_nxt    = 32'h0;
        if (w_count_nxt != CNT_ZERO) begin
            w_head_valid_nxt = 1'b1;
            if (w_count_kept == CNT_ZERO) begin
                // FIFO drains to empty this cycle; head is the word arriving now.
                w_head_inst_nxt = i_imem_rdata;
                w_head_pc_nxt   = r_fetch_pc;
            end else begin
                w_head_inst_nxt = r_mem_inst[w_rptr_nxt];
                w_head_pc_nxt   = r_mem_pc[w_rptr_nxt];
            end
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_redirect || w_space) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    w_state_nxt = w_ack ? S_WAIT : S_DRAIN;
                end else if (w_ack) begin
                    w_state_nxt = w_space ? S_WAIT : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_ack) begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM, fetch address, request and FIFO control registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_addr       <= RESET_PC;
            r_req        <= 1'b0;
            r_count      <= CNT_ZERO;
            r_wptr       <= PTR_ZERO;
            r_rptr       <= PTR_ZERO;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_req        <= (w_state_nxt != S_IDLE);
            r_count      <= w_count_nxt;
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_inst_valid <= w_head_valid_nxt;
            r_inst       <= w_head_inst_nxt;
            r_inst_pc    <= w_head_pc_nxt;
            // In DRAIN the address of the stale request is held.
            if (w_state_nxt == S_WAIT) begin
                r_addr <= w_fetch_pc_nxt;
            end
        end
    end

    // FIFO storage; occupancy is tracked by the pointers above.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem_inst[r_wptr] <= i_imem_rdata;
            r_mem_pc[r_wptr]   <= r_fetch_pc;
        end
    end

    assign o_imem_req   = r_req;
    assign o_imem_addr  = r_addr;
    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_fetch_pc   = r_fetch_pc;

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch prefetch stage between the program counter and the decode stage. Owns the sequential fetch address, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions with their addresses in a small FIFO. Decode consumes them over a valid/ready interface. A redirect from the branch/jump logic flushes the buffer and restarts fetch at a new word-aligned address, discarding any stale in-flight response.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_3000: first fetch address after reset
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- imem_req  out  1  read request, registered
- imem_addr  out  32  read address, stable while imem_req=1
- imem_ack  in  1  read complete; sampled only when imem_req=1
- imem_rdata  in  32  read data, valid with imem_ack
- inst_valid  out  1  FIFO head valid
- inst  out  32  head instruction (0 when inst_valid=0)
- inst_pc  out  32  address of head instruction (0 when inst_valid=0)
- inst_ready  in  1  decode accepts head
- fetch_pc  out  32  address of next/current request

## Operation
- Reset: fetch_pc=RESET_PC, FIFO empty (count=0), state IDLE, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- States: IDLE (no request), WAIT (request outstanding, response kept), DRAIN (request outstanding, response discarded). imem_req=1 in WAIT and DRAIN; imem_addr=fetch_pc in WAIT, latched stale address in DRAIN.
- pop = inst_valid & inst_ready & ~redirect. push = imem_ack in WAIT & ~redirect. Next count = count + push − pop.
- IDLE→WAIT when next count < DEPTH.
- WAIT, ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 mod 2^32 (0xFFFF_FFFC wraps to 0). Stay WAIT if next count < DEPTH, else IDLE. At most one request outstanding; the space check already counts the pushed entry.
- WAIT, no ack: hold imem_addr/imem_req unchanged.
- Redirect (any state): FIFO cleared (count=0), fetch_pc = {redirect_pc[31:2],2'b00}; pop suppressed. WAIT without same-cycle ack → DRAIN; WAIT with same-cycle ack → data dropped, → WAIT at new address; IDLE → WAIT at new address; DRAIN without ack → stay DRAIN, fetch_pc updated; DRAIN with ack → WAIT at new address.
- DRAIN, ack without redirect: discard data, → WAIT at fetch_pc.
- Push and pop same cycle: count unchanged, allowed at full and empty (empty: the pushed entry is not the popped one; pop requires inst_valid).
- Reset overrides redirect and ack; reset mid-request drops it, and memory must tolerate req falling without ack.

## Timing
- imem_req rises the cycle after the first clk edge with rst=0.
- With ack in the same cycle as req (zero-wait memory): one instruction pushed per cycle, imem_addr increments by 4 every cycle while space remains.
- Push-to-valid latency: 1 cycle (entry visible the cycle after the ack edge).
- Redirect-to-request: imem_req high at the new address the cycle after redirect, unless DRAIN is entered. In DRAIN, the new request follows the cycle after the stale ack.
- inst_valid, inst, inst_pc are registered FIFO outputs, with no combinational path from inst_ready or imem_ack.

## Test plan
- Reset then zero-wait memory, inst_ready=1: imem_addr sequence 0x3000,0x3004,0x3008…; inst_pc matches one cycle after each ack; one instruction per cycle.
- inst_ready=0, zero-wait memory: exactly DEPTH=4 acks (0x3000–0x300C), then imem_req=0. Raise inst_ready: fetch resumes at 0x3010 with no loss or duplicate.
- 3-cycle ack latency, redirect to 0x0000_4002 one cycle after req at 0x3008: FIFO empties next cycle, stale data dropped at ack, next req at 0x4000, first inst_pc=0x4000.
- Redirect coincident with ack and pop: FIFO empty next cycle, req at new address next cycle, neither the acked nor the popped word is delivered.
- Redirect to 0xFFFF_FFFC: fetches 0xFFFF_FFFC then 0x0000_0000.
- rst asserted while WAIT with FIFO at 2 entries: next cycle imem_req=0, inst_valid=0, fetch_pc=0x3000. Fetch restarts the following cycle.
